rf_wb_arbiter: RTL and testbench

- Controller for the 32x32 register file's single write port (regWrite/wrReg/wrData).
- Shares the write port between NREQ writeback requesters (e.g. ALU, load unit, mult/div unit) using round-robin arbitration with valid/ready handshakes.
- Keeps a per-register pending-write scoreboard so the issue stage can stall on read-after-write hazards.
- Suppresses writes to $0 so the register file's $0 stays zero.

---
 rtl/rf_wb_arbiter_if.sv | 25 ++
 rtl/rf_wb_arbiter.sv | 110 +++++++++++
 tb/tb_rf_wb_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_if.sv
// Writeback requester bundle and scoreboard reservation port
// shared between the requesters/issue stage and the RF write arbiter.
interface rf_wb_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*5-1:0]  req_reg;
  logic [NREQ*32-1:0] req_data;
  logic               rsv_valid;
  logic [4:0]         rsv_reg;
  logic               rsv_ready;

  modport master (
    output req_valid, req_reg, req_data,
    output rsv_valid, rsv_reg,
    input  req_ready, rsv_ready
  );

  modport slave (
    input  req_valid, req_reg, req_data,
    input  rsv_valid, rsv_reg,
    output req_ready, rsv_ready
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the register file write port with a
// per-register pending-write scoreboard for RAW hazard stalls.
module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int CNTW = 2
) (
  input  logic              clk,
  input  logic              resetN,
  rf_wb_arbiter_if.slave    bus,
  input  logic [4:0]        rs_q,
  input  logic [4:0]        rt_q,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              regWrite,
  output logic [4:0]        wrReg,
  output logic [31:0]       wrData
);
  localparam int PW = (NREQ > 2) ? 2 : 1;

  logic [PW-1:0]   r_last;
  logic [CNTW-1:0] r_cnt [32];

  logic [4:0]      w_reg_a  [NREQ];
  logic [31:0]     w_data_a [NREQ];
  logic [NREQ-1:0] w_gnt;
  logic [PW-1:0]   w_gidx;
  logic [PW-1:0]   w_idx;
  logic            w_any;
  logic [4:0]      w_sreg;
  logic [31:0]     w_sdata;
  logic            w_rsv_hit;
  logic [31:0]     w_inc;
  logic [31:0]     w_dec;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_reg_a[g]  = bus.req_reg[5*g +: 5];
    assign w_data_a[g] = bus.req_data[32*g +: 32];
  end

  // Search starts just after the last winner and wraps.
  always_comb begin
    w_gnt  = '0;
    w_gidx = '0;
    w_idx  = '0;
    w_any  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = PW'((int'(r_last) + k) % NREQ);
      if (!w_any && bus.req_valid[w_idx]) begin
        w_any        = 1'b1;
        w_gnt[w_idx] = 1'b1;
        w_gidx       = w_idx;
      end
    end
  end

  assign w_sreg        = w_reg_a[w_gidx];
  assign w_sdata       = w_data_a[w_gidx];
  assign bus.req_ready = w_gnt;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      regWrite <= 1'b0;
      wrReg    <= '0;
      wrData   <= '0;
      r_last   <= PW'(NREQ - 1);
    end else if (w_any) begin
      regWrite <= (w_sreg != 5'd0);
      wrReg    <= w_sreg;
      wrData   <= w_sdata;
      r_last   <= w_gidx;
    end else begin
      regWrite <= 1'b0;
    end
  end

  assign bus.rsv_ready = ~&r_cnt[bus.rsv_reg];
  assign w_rsv_hit = bus.rsv_valid && bus.rsv_ready
                   && (bus.rsv_reg != 5'd0);

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int i = 0; i < 32; i++) begin
      w_inc[i] = w_rsv_hit && (bus.rsv_reg == 5'(i));
      w_dec[i] = regWrite && (wrReg == 5'(i));
    end
  end

  // A same-edge reserve and retire on one register cancel out.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < 32; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (w_inc[i] && !w_dec[i])
          r_cnt[i] <= r_cnt[i] + CNTW'(1);
        else if (w_dec[i] && !w_inc[i] && r_cnt[i] != '0)
          r_cnt[i] <= r_cnt[i] - CNTW'(1);
      end
    end
  end

  assign rs_busy = (r_cnt[rs_q] != '0);
  assign rt_busy = (r_cnt[rt_q] != '0);

  a_no_underflow: assert property (
    @(posedge clk) disable iff (!resetN)
    regWrite |-> (r_cnt[wrReg] != '0)
  );
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with a per-cycle reference model
// of round-robin grant, write pipeline and pending-write counters.
module tb_rf_wb_arbiter;
  localparam int NREQ = 3;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.NREQ(NREQ)) bus ();

  logic [4:0]  rs_q, rt_q;
  logic        rs_busy, rt_busy, regWrite;
  logic [4:0]  wrReg;
  logic [31:0] wrData;

  rf_wb_arbiter #(.NREQ(NREQ), .CNTW(2)) dut (
    .clk      (clk),
    .resetN   (resetN),
    .bus      (bus),
    .rs_q     (rs_q),
    .rt_q     (rt_q),
    .rs_busy  (rs_busy),
    .rt_busy  (rt_busy),
    .regWrite (regWrite),
    .wrReg    (wrReg),
    .wrData   (wrData)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: counts of outstanding writes per register,
  // the last winner, and the write in flight to the register file.
  int          m_cnt [32];
  int          m_last;
  logic        m_rw;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;

  function automatic int m_pick(logic [NREQ-1:0] v);
    for (int j = 1; j <= NREQ; j++)
      if (v[(m_last + j) % NREQ]) return (m_last + j) % NREQ;
    return -1;
  endfunction

  always @(posedge clk or negedge resetN) begin : model
    int g, inc_r, dec_r;
    if (!resetN) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_last = NREQ - 1;
      m_rw = 1'b0; m_wr = '0; m_wd = '0;
    end else begin
      g = m_pick(bus.req_valid);
      inc_r = (bus.rsv_valid && bus.rsv_reg != 0 && m_cnt[bus.rsv_reg] < 3)
            ? int'(bus.rsv_reg) : -1;
      dec_r = m_rw ? int'(m_wr) : -1;
      if (inc_r >= 0) m_cnt[inc_r]++;
      if (dec_r >= 0 && m_cnt[dec_r] > 0) m_cnt[dec_r]--;
      if (g >= 0) begin
        m_wr = bus.req_reg[5*g +: 5];
        m_wd = bus.req_data[32*g +: 32];
        m_rw = (m_wr != 0);
        m_last = g;
      end else begin
        m_rw = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : compare
    int g;
    g = m_pick(bus.req_valid);
    chk("req_ready", 32'(bus.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    chk("rsv_ready", 32'(bus.rsv_ready), 32'(m_cnt[bus.rsv_reg] < 3));
    chk("rs_busy", 32'(rs_busy), 32'(m_cnt[rs_q] != 0));
    chk("rt_busy", 32'(rt_busy), 32'(m_cnt[rt_q] != 0));
    chk("regWrite", 32'(regWrite), 32'(m_rw));
    chk("wrReg", 32'(wrReg), 32'(m_wr));
    chk("wrData", wrData, m_wd);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reserve(logic [4:0] r);
    bus.rsv_valid = 1'b1;
    bus.rsv_reg   = r;
    tick();
    bus.rsv_valid = 1'b0;
    bus.rsv_reg   = '0;
  endtask

  int          exp_g [6] = '{1, 2, 4, 1, 2, 4};
  int          exp_w [6] = '{5, 6, 7, 5, 6, 7};
  logic [2:0]  gq [6];
  logic [4:0]  wq [6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0; bus.req_reg = '0; bus.req_data = '0;
    bus.rsv_valid = 1'b0; bus.rsv_reg = '0;
    rs_q = '0; rt_q = '0;
    #1;
    chk("rst_regWrite", 32'(regWrite), 0);
    chk("rst_wrReg", 32'(wrReg), 0);
    chk("rst_wrData", wrData, 0);
    chk("rst_ready", 32'(bus.req_ready), 0);
    for (int r = 0; r < 32; r++) begin
      rs_q = 5'(r);
      #2;
      chk("rst_busy", 32'(rs_busy), 0);
    end
    rs_q = '0;
    @(negedge clk);
    resetN = 1'b1;
    tick();

    // Round robin with all three requesters asserting
    reserve(5); reserve(5); reserve(6);
    reserve(6); reserve(7); reserve(7);
    rs_q = 5; rt_q = 7;
    #1;
    chk("busy5_rsv", 32'(rs_busy), 1);
    chk("busy7_rsv", 32'(rt_busy), 1);
    bus.req_reg   = {5'd7, 5'd6, 5'd5};
    bus.req_data  = {32'h7007, 32'h6006, 32'h5005};
    bus.req_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1;
      gq[i] = bus.req_ready;
      tick();
      wq[i] = wrReg;
      chk("rr_regWrite", 32'(regWrite), 1);
    end
    bus.req_valid = '0;
    for (int i = 0; i < 6; i++) begin
      chk("rr_grant", 32'(gq[i]), 32'(exp_g[i]));
      chk("rr_wrReg", 32'(wq[i]), 32'(exp_w[i]));
    end
    chk("rr_wrData", wrData, 32'h7007);
    tick();
    chk("busy5_done", 32'(rs_busy), 0);
    chk("busy7_done", 32'(rt_busy), 0);

    // Write to $0 consumes the slot but never reaches the RF
    bus.req_reg   = '0;
    bus.req_data  = {32'h0, 32'hDEADBEEF, 32'h0};
    bus.req_valid = 3'b010;
    #1;
    chk("r0_ready", 32'(bus.req_ready), 32'b010);
    tick();
    bus.req_valid = '0;
    chk("r0_regWrite", 32'(regWrite), 0);
    chk("r0_wrData", wrData, 32'hDEADBEEF);
    tick();

    // Two reservations of $9 retire one write at a time
    reserve(9); reserve(9);
    rs_q = 9;
    #1;
    chk("busy9_rsv", 32'(rs_busy), 1);
    bus.req_reg   = {5'd9, 5'd0, 5'd9};
    bus.req_data  = {32'h9002, 32'h0, 32'h9001};
    bus.req_valid = 3'b100;
    #1;
    chk("r9_ready_a", 32'(bus.req_ready), 32'b100);
    tick();
    chk("r9_wr_a", 32'(wrReg), 9);
    chk("busy9_a", 32'(rs_busy), 1);
    bus.req_valid = 3'b001;
    tick();
    chk("busy9_b", 32'(rs_busy), 1);
    chk("r9_data_b", wrData, 32'h9001);
    bus.req_valid = '0;
    tick();
    chk("busy9_clr", 32'(rs_busy), 0);

    // Same-edge reserve/retire on $4, then saturation
    reserve(4);
    bus.req_reg   = {5'd0, 5'd4, 5'd0};
    bus.req_data  = {32'h0, 32'h4444, 32'h0};
    bus.req_valid = 3'b010;
    tick();
    bus.req_valid = '0;
    chk("r4_regWrite", 32'(regWrite), 1);
    bus.rsv_valid = 1'b1;
    bus.rsv_reg   = 5'd4;
    rt_q = 4;
    tick();
    chk("busy4_keep", 32'(rt_busy), 1);
    tick();
    #1;
    chk("rsv4_ready_c2", 32'(bus.rsv_ready), 1);
    tick();
    #1;
    chk("rsv4_sat", 32'(bus.rsv_ready), 0);
    tick();
    bus.rsv_valid = 1'b0;
    bus.rsv_reg   = '0;

    // Asynchronous reset mid-write
    reserve(12); reserve(12);
    bus.req_reg   = {5'd0, 5'd12, 5'd0};
    bus.req_data  = {32'h0, 32'hC0C0, 32'h0};
    bus.req_valid = 3'b010;
    tick();
    bus.req_valid = '0;
    rs_q = 12;
    #1;
    chk("r12_regWrite", 32'(regWrite), 1);
    chk("busy12", 32'(rs_busy), 1);
    resetN = 1'b0;
    #1;
    chk("ar_regWrite", 32'(regWrite), 0);
    chk("ar_wrReg", 32'(wrReg), 0);
    chk("ar_wrData", wrData, 0);
    chk("ar_busy12", 32'(rs_busy), 0);
    chk("ar_busy4", 32'(rt_busy), 0);
    bus.req_reg   = '0;
    bus.req_valid = 3'b111;
    #1;
    chk("ar_ready0", 32'(bus.req_ready), 32'b001);
    @(negedge clk);
    resetN = 1'b1;
    tick();
    chk("ar_ready1", 32'(bus.req_ready), 32'b010);
    bus.req_valid = '0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
